// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   Owns the program counter, issues word reads to instruction memory
//   (which may insert wait states), registers the returned word for decode,
//   and picks the next PC from the control flow reported by decode.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and byte address (imem_addr == pc)
//   imem_ready/rdata    memory handshake and returned instruction word
//   instr/instr_valid   registered instruction presented to decode
//   pc, pc_plus4        current/delivered instruction address and its link value
//   stall               decode cannot accept; hold the delivered instruction
//   branch_taken, is_jump, is_jr, imm16, jaddr26, jr_addr
//                       control flow for the delivered instruction
//   fault               sticky misaligned-target fault
module fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              is_jump,
    input  logic              is_jr,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr26,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              fault
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_WAIT    = 2'b01,
        ST_DELIVER = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [31:0]         instr_r;
    logic                valid_r, valid_s;
    logic                req_r, req_s;
    logic                fault_r, fault_s;
    logic                load_instr_s;
    logic                load_pc_s;
    logic [ADDR_W-1:0]   next_pc_s;

    // Next PC selection; priority jr > jump > branch > sequential.
    function automatic logic [ADDR_W-1:0] calc_next_pc(
        input logic [ADDR_W-1:0] pc_v,
        input logic              jr_v,
        input logic              jmp_v,
        input logic              br_v,
        input logic [15:0]       imm_v,
        input logic [25:0]       ja_v,
        input logic [ADDR_W-1:0] jra_v
    );
        logic [ADDR_W-1:0] seq_v;
        logic [ADDR_W-1:0] off_v;
        logic [ADDR_W-1:0] res_v;
        seq_v = pc_v + ADDR_W'(32'd4);
        off_v = {{(ADDR_W-18){imm_v[15]}}, imm_v, 2'b00};
        if (jr_v) begin
            res_v = jra_v;
        end else if (jmp_v) begin
            res_v = {seq_v[ADDR_W-1:28], ja_v, 2'b00};
        end else if (br_v) begin
            res_v = seq_v + off_v;
        end else begin
            res_v = seq_v;
        end
        return res_v;
    endfunction

    // Candidate next PC for the delivered instruction.
    always_comb begin
        next_pc_s = calc_next_pc(pc_r, is_jr, is_jump, branch_taken, imm16, jaddr26, jr_addr);
    end

    // Next-state and next-output decode of the fetch FSM.
    always_comb begin
        state_s      = state_r;
        req_s        = 1'b0;
        valid_s      = 1'b0;
        fault_s      = fault_r;
        load_instr_s = 1'b0;
        load_pc_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                // The first cycle out of reset has no request outstanding yet,
                // so a ready seen then must not be taken as a response.
                if (req_r && imem_ready) begin
                    state_s      = ST_DELIVER;
                    valid_s      = 1'b1;
                    load_instr_s = 1'b1;
                end else if (req_r) begin
                    state_s = ST_WAIT;
                    req_s   = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                    req_s   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    state_s      = ST_DELIVER;
                    valid_s      = 1'b1;
                    load_instr_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                    req_s   = 1'b1;
                end
            end
            ST_DELIVER: begin
                if (stall) begin
                    state_s = ST_DELIVER;
                    valid_s = 1'b1;
                end else if (next_pc_s[1:0] != 2'b00) begin
                    // Misaligned target: keep pc pointing at the offender.
                    state_s = ST_FAULT;
                    fault_s = 1'b1;
                end else begin
                    state_s   = ST_FETCH;
                    req_s     = 1'b1;
                    load_pc_s = 1'b1;
                end
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
                fault_s = 1'b1;
            end
            default: begin
                // Unreachable encoding: park safely.
                state_s = ST_FAULT;
                fault_s = 1'b1;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            valid_r <= 1'b0;
            req_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_s;
            valid_r <= valid_s;
            req_r   <= req_s;
            fault_r <= fault_s;
            if (load_instr_s) begin
                instr_r <= imem_rdata;
            end
            if (load_pc_s) begin
                pc_r <= next_pc_s;
            end
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + ADDR_W'(32'd4);
    assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a word memory model,
// configurable wait states and a reference next-PC model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic        is_jump;
    logic        is_jr;
    logic [15:0] imm16;
    logic [25:0] jaddr26;
    logic [31:0] jr_addr;
    logic        fault;

    logic [31:0] mem [0:63];
    int          wait_n;
    int          req_cnt;
    logic        stray_ready;
    int          errors;
    int          checks;
    logic [31:0] exp_pc;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .stall(stall), .branch_taken(branch_taken),
        .is_jump(is_jump), .is_jr(is_jr),
        .imm16(imm16), .jaddr26(jaddr26), .jr_addr(jr_addr),
        .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after wait_n request cycles; stray_ready injects a bogus ready.
    always @(posedge clk) begin
        if (imem_req) req_cnt <= req_cnt + 1;
        else          req_cnt <= 0;
    end
    assign imem_ready = (imem_req && (req_cnt >= wait_n)) || stray_ready;
    assign imem_rdata = mem[imem_addr[7:2]];

    // Reference next-PC rule written with plain arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] p, input bit jr, input bit jmp,
                                               input bit br, input logic [15:0] imm,
                                               input logic [25:0] ja, input logic [31:0] jra);
        logic [31:0] nxt;
        nxt = p + 32'd4;
        if (jr)  return jra;
        if (jmp) return (nxt & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
        if (br)  return nxt + 32'($signed(imm)) * 32'd4;
        return nxt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        stall = 1'b0; branch_taken = 1'b0; is_jump = 1'b0; is_jr = 1'b0;
        imm16 = 16'h0000; jaddr26 = 26'h0; jr_addr = 32'h0;
    endtask

    // Fetch one instruction from exp_pc, optionally stall, then apply controls.
    task automatic deliver_step(input int wn, input int stall_n, input bit jr, input bit jmp,
                                input bit br, input logic [15:0] imm, input logic [25:0] ja,
                                input logic [31:0] jra);
        int n;
        wait_n = wn;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++;
        if (imem_addr !== exp_pc)
            begin errors++; $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_pc); end
        n = 0;
        while (!instr_valid && n < 40) begin tick(); n++; end
        checks++;
        if (n !== wn + 1)
            begin errors++; $display("FAIL latency: got %0d cycles want %0d", n, wn + 1); end
        checks++;
        if (pc !== exp_pc)
            begin errors++; $display("FAIL deliver_pc: got %h want %h", pc, exp_pc); end
        checks++;
        if (instr !== mem[exp_pc[7:2]])
            begin errors++; $display("FAIL instr: got %h want %h", instr, mem[exp_pc[7:2]]); end
        checks++;
        if (pc_plus4 !== exp_pc + 32'd4)
            begin errors++; $display("FAIL pc_plus4: got %h want %h", pc_plus4, exp_pc + 32'd4); end
        for (int s = 0; s < stall_n; s++) begin
            // Controls (including a misaligned jr) must be ignored while stalled.
            stall = 1'b1; is_jr = 1'b1; jr_addr = 32'h0000_0003;
            is_jump = 1'($urandom_range(0, 1)); branch_taken = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (instr_valid !== 1'b1 || pc !== exp_pc || instr !== mem[exp_pc[7:2]] || fault !== 1'b0)
                begin errors++; $display("FAIL stall_hold: valid=%b pc=%h instr=%h fault=%b want 1 %h %h 0",
                                         instr_valid, pc, instr, fault, exp_pc, mem[exp_pc[7:2]]); end
        end
        clear_ctrl();
        is_jr = jr; is_jump = jmp; branch_taken = br; imm16 = imm; jaddr26 = ja; jr_addr = jra;
        tick();
        clear_ctrl();
        exp_pc = model_next(exp_pc, jr, jmp, br, imm, ja, jra);
        checks++;
        if (pc !== exp_pc || instr_valid !== 1'b0)
            begin errors++; $display("FAIL next_pc: got pc=%h valid=%b want %h 0", pc, instr_valid, exp_pc); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || fault !== 1'b0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL reset_state: pc=%h instr=%h valid=%b fault=%b req=%b want all 0",
                                     pc, instr, instr_valid, fault, imem_req); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin errors++; $display("FAIL reset_release: req=%b addr=%h want 1 0", imem_req, imem_addr); end
        exp_pc = 32'h0;
    endtask

    task automatic test_sequential();
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h1234, 26'h0, 32'h0);        // 0  -> 4
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);           // 4  -> 8
        deliver_step(0, 0, 1'b0, 1'b0, 1'b1, 16'd2, 26'h0, 32'h0);           // 8  -> 20
        deliver_step(0, 0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 26'h0, 32'h0);        // 20 -> 16
        deliver_step(0, 0, 1'b0, 1'b1, 1'b0, 16'h0, 26'd10, 32'h0);          // 16 -> 40
        checks++;
        if (exp_pc !== 32'd40) begin errors++; $display("FAIL jump_target: model %h want 28", exp_pc); end
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);           // 40 -> 44
    endtask

    task automatic test_not_taken();
        deliver_step(0, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'd12);          // jr -> 12
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0040, 26'h0, 32'h0);        // bne not taken -> 16
    endtask

    task automatic test_wait_stall();
        deliver_step(3, 2, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        deliver_step(1, 1, 1'b0, 1'b0, 1'b1, 16'h0003, 26'h0, 32'h0);
    endtask

    task automatic test_priority();
        deliver_step(0, 0, 1'b1, 1'b1, 1'b1, 16'h0005, 26'h3, 32'h0000_0080);
        checks++;
        if (pc !== 32'h80) begin errors++; $display("FAIL priority: got %h want 00000080", pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            deliver_step(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         16'($urandom()), 26'($urandom()), $urandom() & 32'hFFFF_FFFC);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        wait_n = 5;
        tick(); tick();
        rst_n = 1'b0;
        #2;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL reset_mid_wait: valid=%b pc=%h req=%b want 0 0 0",
                                     instr_valid, pc, imem_req); end
        tick();
        rst_n = 1'b1;
        exp_pc = 32'h0;
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
        n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        rst_n = 1'b0;
        #2;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h0)
            begin errors++; $display("FAIL reset_mid_deliver: valid=%b pc=%h instr=%h want 0 0 0",
                                     instr_valid, pc, instr); end
        tick();
        rst_n = 1'b1;
        exp_pc = 32'h0;
    endtask

    task automatic test_fault();
        int n;
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);           // pc -> 4
        wait_n = 0;
        n = 0;
        while (!instr_valid && n < 20) begin tick(); n++; end
        is_jr = 1'b1; is_jump = 1'b1; jr_addr = 32'h0000_0102;
        tick();
        clear_ctrl();
        checks++;
        if (fault !== 1'b1 || pc !== exp_pc || instr_valid !== 1'b0 || imem_req !== 1'b0)
            begin errors++; $display("FAIL fault_entry: fault=%b pc=%h valid=%b req=%b want 1 %h 0 0",
                                     fault, pc, instr_valid, imem_req, exp_pc); end
        stray_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (fault !== 1'b1 || pc !== exp_pc || instr_valid !== 1'b0 || imem_req !== 1'b0)
                begin errors++; $display("FAIL fault_sticky: fault=%b pc=%h valid=%b req=%b want 1 %h 0 0",
                                         fault, pc, instr_valid, imem_req, exp_pc); end
        end
        stray_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if (fault !== 1'b0 || pc !== 32'h0)
            begin errors++; $display("FAIL fault_reset: fault=%b pc=%h want 0 0", fault, pc); end
        tick();
        rst_n = 1'b1;
        exp_pc = 32'h0;
        deliver_step(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    initial begin
        errors = 0; checks = 0; wait_n = 0; req_cnt = 0; stray_ready = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        clear_ctrl();
        test_reset();
        test_sequential();
        test_not_taken();
        test_wait_stall();
        test_priority();
        test_random();
        test_reset_abort();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
